sprite_palette_lut: RTL and testbench
=====================================

Name: sprite_palette_lut

Overview:
- Parametrised, registered palette lookup for sprite and tile pixel indices.
- Holds NUM_PAL runtime-writable palettes of 2^IDX_W entries. Flags the transparent index and applies a frame-timed hit-flash colour override.
- Sits between the sprite ROM index fetch and the VGA colour mux. One instance per sprite layer.

Parameters:
- IDX_W, 4, pixel index width; each palette has 2^IDX_W entries.
- CH_W, 4, bits per colour channel.
- NUM_PAL, 4, number of palettes; BANK_W = $clog2(NUM_PAL), minimum 1.
- TRANSP_IDX, 0, index reported as transparent in every palette.
- FLASH_FRAMES, 8, total frames a hit-flash lasts.
- FLASH_TOGGLE, 2, frames per on/off phase; must be >= 1.

Ports:
- clk  in  1  system clock (pixel clock domain).
- reset_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  lookup request this cycle.
- pix_index  in  IDX_W  palette index.
- pix_bank  in  BANK_W  palette select.
- out_valid  out  1  pix_valid delayed 2 cycles.
- red, green, blue  out  CH_W each  looked-up or flash colour.
- out_transp  out  1  index equals TRANSP_IDX; colour outputs forced to 0.
- wr_en  in  1  palette entry write strobe.
- wr_bank  in  BANK_W  bank to write.
- wr_index  in  IDX_W  entry to write.
- wr_rgb  in  3*CH_W  {r,g,b} written.
- frame_start  in  1  one-cycle pulse per frame (vsync edge).
- flash_req  in  1  start or restart a hit-flash.
- flash_rgb  in  3*CH_W  override colour used in the flash-on phase.
- flash_active  out  1  FSM not IDLE.

Behaviour:
- Storage:
  - Flop array NUM_PAL x 2^IDX_W x 3*CH_W.
  - On reset, bank 0 loads DEFAULT_PALETTE from the package. All other banks reset to 0.
- Write: wr_en writes wr_rgb into [wr_bank][wr_index] at the clock edge. Any wr_bank >= NUM_PAL is ignored.
- Read pipeline, latency 2:
  - Stage 1 registers the array entry, the index==TRANSP_IDX compare and valid.
  - Stage 2 registers the final colour, out_transp and out_valid.
  - Any pix_bank >= NUM_PAL reads as colour 0 with out_transp = 1.
- Read/write collision, same bank and index in the same cycle: stage 1 captures the OLD value. The new value is visible to reads issued the next cycle or later.
- out_valid = 0: outputs hold their previous values. No read-enable gating of the array.
- Stage 2 colour priority:
  - transp → 0.
  - Else flash-on phase → flash_rgb.
  - Else stored colour.
- Flash FSM states are IDLE, ON, OFF.
  - remain counter: $clog2(FLASH_FRAMES+1) bits. phase counter: $clog2(FLASH_TOGGLE+1) bits.
  - IDLE + flash_req → ON, remain = FLASH_FRAMES, phase = FLASH_TOGGLE.
  - ON/OFF + frame_start:
    - remain decrements and phase decrements.
    - Phase reaching 0 toggles ON↔OFF and reloads phase.
    - Remain reaching 0 → IDLE, regardless of phase.
  - ON/OFF + flash_req: restart to ON with full counters. flash_req takes priority over a simultaneous frame_start.
  - IDLE ignores frame_start.
- Flash application:
  - The flash state is sampled at stage 2, so a state change affects pixels in stage 2 on the following cycle.
  - The flash never overrides transparent pixels.
- Reset values:
  - out_valid = 0, red/green/blue = 0, out_transp = 0, flash_active = 0.
  - FSM = IDLE, counters = 0, pipeline regs = 0.
- Reset asserted mid-flash or mid-pipeline: everything clears immediately. In-flight pixels are dropped (out_valid = 0).
- FLASH_FRAMES = 0: flash_req is ignored and the FSM stays IDLE.

Decomposition:
- Package sprite_palette_pkg holds:
  - flash_state_t enum (IDLE, ON, OFF).
  - rgb_t packed struct {r, g, b} of CH_W=4.
  - DEFAULT_PALETTE constant [0:15] of rgb_t, index 0 black.
- One sub-module, palette_flash_fsm, holds the FSM and counters. Its outputs are flash_on and flash_active.

Test Plan:
- Reset, then pix_valid, bank 0, index 1 → 2 cycles later out_valid = 1 and rgb equals DEFAULT_PALETTE[1]; earlier cycles show out_valid = 0.
- Write bank 2, index 5 = 12'hA5C, with a same-cycle read of [2][5] → the first read returns 0 (old value); a read issued the next cycle returns A/5/C.
- Read index 0 (TRANSP_IDX) in any bank, with a flash active → out_transp = 1 and rgb = 0.
- flash_req, flash_rgb = 12'hFFF, then 8 frame_start pulses while streaming index 3:
  - Colour is FFF for 2 frames, stored for 2, FFF for 2, stored for 2.
  - flash_active drops after the 8th frame_start.
- flash_req and frame_start in the same cycle mid-flash (remain = 1) → FSM in ON with remain = 8; it does not go IDLE.
- pix_bank = 3 with NUM_PAL = 3, then reset_n low for 1 cycle mid-stream → bank 3 reads rgb = 0 with out_transp = 1; reset clears out_valid and flash_active immediately.

Source files
------------

// File: rtl/sprite_palette_lut_pkg.sv
`default_nettype none
// ============================================================================
// sprite_palette_pkg : shared types, flash FSM states and the default palette
// Revision: 1.0
// ============================================================================
package sprite_palette_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } flash_state_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // 16-colour CGA-style ramp; entry 0 is black so the transparent slot is dark
    localparam rgb_t DEFAULT_PALETTE [0:15] = '{
        rgb_t'(12'h000), rgb_t'(12'h00A), rgb_t'(12'h0A0), rgb_t'(12'h0AA),
        rgb_t'(12'hA00), rgb_t'(12'hA0A), rgb_t'(12'hA50), rgb_t'(12'hAAA),
        rgb_t'(12'h555), rgb_t'(12'h55F), rgb_t'(12'h5F5), rgb_t'(12'h5FF),
        rgb_t'(12'hF55), rgb_t'(12'hF5F), rgb_t'(12'hFF5), rgb_t'(12'hFFF)
    };

    function automatic logic [11:0] default_rgb(input int i);
        logic [3:0] w_i;
        w_i = i[3:0];
        if (i < 16) return DEFAULT_PALETTE[w_i];
        return 12'h000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_palette_lut_if.sv
`default_nettype none
// ============================================================================
// sprite_palette_lut_if : pixel lookup stream and palette write bus
// Revision: 1.0
// ============================================================================
interface sprite_palette_lut_if #(
    parameter int IDX_W  = 4,
    parameter int CH_W   = 4,
    parameter int BANK_W = 2
);
    logic              pix_valid;
    logic [IDX_W-1:0]  pix_index;
    logic [BANK_W-1:0] pix_bank;
    logic              out_valid;
    logic [CH_W-1:0]   red;
    logic [CH_W-1:0]   green;
    logic [CH_W-1:0]   blue;
    logic              out_transp;
    logic              wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [IDX_W-1:0]  wr_index;
    logic [3*CH_W-1:0] wr_rgb;

    modport master (
        output pix_valid, pix_index, pix_bank, wr_en, wr_bank, wr_index, wr_rgb,
        input  out_valid, red, green, blue, out_transp
    );

    modport slave (
        input  pix_valid, pix_index, pix_bank, wr_en, wr_bank, wr_index, wr_rgb,
        output out_valid, red, green, blue, out_transp
    );
endinterface
`default_nettype wire

// File: rtl/sprite_palette_lut_flash_fsm.sv
`default_nettype none
// ============================================================================
// palette_flash_fsm : frame-timed hit-flash sequencer (ON/OFF blink, then idle)
// Revision: 1.0
// ============================================================================
module palette_flash_fsm
    import sprite_palette_pkg::*;
#(
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_TOGGLE = 2
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic i_frame_start,
    input  wire logic i_flash_req,
    output logic      o_flash_on,
    output logic      o_flash_active
);

    localparam int RW = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;
    localparam int PW = $clog2(FLASH_TOGGLE + 1);
    localparam logic [RW-1:0] c_REMAIN_INIT = RW'(FLASH_FRAMES);
    localparam logic [PW-1:0] c_PHASE_INIT  = PW'(FLASH_TOGGLE);
    localparam logic          c_FLASH_EN    = (FLASH_FRAMES > 0);

    flash_state_t    r_state, w_state_nx;
    logic [RW-1:0]   r_remain, w_remain_nx, w_remain_dec;
    logic [PW-1:0]   r_phase, w_phase_nx, w_phase_dec;

    assign w_remain_dec = r_remain - 1'b1;
    assign w_phase_dec  = r_phase - 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_remain <= '0;
            r_phase  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_remain <= w_remain_nx;
            r_phase  <= w_phase_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_remain_nx = r_remain;
        w_phase_nx  = r_phase;
        case (r_state)
            IDLE: begin
                if (i_flash_req && c_FLASH_EN) begin
                    w_state_nx  = ON;
                    w_remain_nx = c_REMAIN_INIT;
                    w_phase_nx  = c_PHASE_INIT;
                end
            end
            ON, OFF: begin
                // a restart wins over the frame tick landing in the same cycle
                if (i_flash_req) begin
                    w_state_nx  = ON;
                    w_remain_nx = c_REMAIN_INIT;
                    w_phase_nx  = c_PHASE_INIT;
                end else if (i_frame_start) begin
                    if (w_remain_dec == '0) begin
                        w_state_nx  = IDLE;
                        w_remain_nx = '0;
                        w_phase_nx  = '0;
                    end else begin
                        w_remain_nx = w_remain_dec;
                        if (w_phase_dec == '0) begin
                            w_state_nx = (r_state == ON) ? OFF : ON;
                            w_phase_nx = c_PHASE_INIT;
                        end else begin
                            w_phase_nx = w_phase_dec;
                        end
                    end
                end
            end
            default: begin
                w_state_nx  = IDLE;
                w_remain_nx = '0;
                w_phase_nx  = '0;
            end
        endcase
    end

    assign o_flash_on     = (r_state == ON);
    assign o_flash_active = (r_state != IDLE);

endmodule
`default_nettype wire

// File: rtl/sprite_palette_lut.sv
`default_nettype none
// ============================================================================
// sprite_palette_lut : banked, runtime-writable palette with a 2-stage lookup
// Revision: 1.0
// ============================================================================
module sprite_palette_lut
    import sprite_palette_pkg::*;
#(
    parameter int IDX_W        = 4,
    parameter int CH_W         = 4,
    parameter int NUM_PAL      = 4,
    parameter int TRANSP_IDX   = 0,
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_TOGGLE = 2
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    sprite_palette_lut_if.slave   bus,
    input  wire logic             frame_start,
    input  wire logic             flash_req,
    input  wire logic [3*CH_W-1:0] flash_rgb,
    output logic                  flash_active
);

    localparam int BANK_W  = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1;
    localparam int RGB_W   = 3 * CH_W;
    localparam int ENTRIES = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] c_TRANSP = TRANSP_IDX[IDX_W-1:0];

    logic [RGB_W-1:0] r_pal [NUM_PAL][ENTRIES];

    logic [RGB_W-1:0] w_rd_rgb;
    logic             w_bank_ok;
    logic             w_flash_on;

    logic             r_s1_valid;
    logic             r_s1_transp;
    logic [RGB_W-1:0] r_s1_rgb;

    logic             r_out_valid;
    logic             r_out_transp;
    logic [RGB_W-1:0] r_out_rgb;

    // Banks at or beyond NUM_PAL never match, so out-of-range writes are dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_PAL; b++) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    r_pal[b][i] <= (b == 0) ? RGB_W'(default_rgb(i)) : '0;
                end
            end
        end else if (bus.wr_en) begin
            for (int b = 0; b < NUM_PAL; b++) begin
                if (bus.wr_bank == BANK_W'(b)) begin
                    r_pal[b][bus.wr_index] <= bus.wr_rgb;
                end
            end
        end
    end

    always_comb begin
        w_rd_rgb  = '0;
        w_bank_ok = 1'b0;
        for (int b = 0; b < NUM_PAL; b++) begin
            if (bus.pix_bank == BANK_W'(b)) begin
                w_rd_rgb  = r_pal[b][bus.pix_index];
                w_bank_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_transp <= 1'b0;
            r_s1_rgb    <= '0;
        end else begin
            r_s1_valid  <= bus.pix_valid;
            r_s1_transp <= (bus.pix_index == c_TRANSP) || !w_bank_ok;
            r_s1_rgb    <= w_rd_rgb;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_transp <= 1'b0;
            r_out_rgb    <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_transp <= r_s1_transp;
                if (r_s1_transp)     r_out_rgb <= '0;
                else if (w_flash_on) r_out_rgb <= flash_rgb;
                else                 r_out_rgb <= r_s1_rgb;
            end
        end
    end

    palette_flash_fsm #(
        .FLASH_FRAMES (FLASH_FRAMES),
        .FLASH_TOGGLE (FLASH_TOGGLE)
    ) u_flash_fsm (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_frame_start  (frame_start),
        .i_flash_req    (flash_req),
        .o_flash_on     (w_flash_on),
        .o_flash_active (flash_active)
    );

    assign bus.out_valid  = r_out_valid;
    assign bus.out_transp = r_out_transp;
    assign {bus.red, bus.green, bus.blue} = r_out_rgb;

endmodule
`default_nettype wire

// File: tb/tb_sprite_palette_lut.sv
`default_nettype none
// ============================================================================
// tb_sprite_palette_lut : scoreboard bench for the palette lookup and hit-flash
// Revision: 1.0
// ============================================================================
module tb_sprite_palette_lut;

    localparam int IDX_W  = 4;
    localparam int CH_W   = 4;
    localparam int BANK_W = 2;

    localparam logic [11:0] c_DEF [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        flash_req = 1'b0;
    logic [11:0] flash_rgb = 12'h000;
    logic        flash_active;

    always #5 clk = ~clk;

    sprite_palette_lut_if #(.IDX_W(IDX_W), .CH_W(CH_W), .BANK_W(BANK_W)) bus ();

    sprite_palette_lut #(
        .IDX_W(IDX_W), .CH_W(CH_W), .NUM_PAL(3), .TRANSP_IDX(0),
        .FLASH_FRAMES(8), .FLASH_TOGGLE(2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .frame_start  (frame_start),
        .flash_req    (flash_req),
        .flash_rgb    (flash_rgb),
        .flash_active (flash_active)
    );

    typedef struct {
        logic [11:0] rgb;
        logic        transp;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        r_mon;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [11:0] m_pal [4][16];
    logic        m_on = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 16; i++)
                m_pal[b][i] = (b == 0) ? c_DEF[i] : 12'h000;
        m_on = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [1:0] b, input logic [3:0] i);
        exp_t e;
        e.transp = (i == 4'd0) || (b == 2'd3);
        if (e.transp)  e.rgb = 12'h000;
        else if (m_on) e.rgb = flash_rgb;
        else           e.rgb = m_pal[b][i];
        e.cyc = cyc;
        sb.push_back(e);
        bus.pix_valid = 1'b1;
        bus.pix_bank  = b;
        bus.pix_index = i;
        step();
        bus.pix_valid = 1'b0;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
    endtask

    task automatic flash_start();
        flash_req = 1'b1;
        step();
        flash_req = 1'b0;
        m_on = 1'b1;
    endtask

    // Every output beat must match the oldest pending request, two cycles on
    always @(negedge clk) begin
        if (reset_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", sb.size(), 1);
            end else begin
                r_mon = sb.pop_front();
                check_eq("rgb", {bus.red, bus.green, bus.blue}, r_mon.rgb);
                check_eq("transp", bus.out_transp, r_mon.transp);
                check_eq("latency", cyc, r_mon.cyc + 2);
            end
        end
    end

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_index = '0;
        bus.pix_bank  = '0;
        bus.wr_en     = 1'b0;
        bus.wr_bank   = '0;
        bus.wr_index  = '0;
        bus.wr_rgb    = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", bus.out_valid, 0);
        check_eq("rst_rgb", {bus.red, bus.green, bus.blue}, 0);
        check_eq("rst_transp", bus.out_transp, 0);
        check_eq("rst_flash", flash_active, 0);
        reset_n = 1'b1;
        step();

        pix(2'd0, 4'd1);
        check_eq("lat_early", bus.out_valid, 0);
        step();
        check_eq("lat_valid", bus.out_valid, 1);
        check_eq("lat_rgb", {bus.red, bus.green, bus.blue}, 12'h00A);
        for (int i = 0; i < 16; i++) pix(2'd0, 4'(i));
        pix(2'd1, 4'd7);
        step();

        // same-cycle write and read of [2][5] returns the old contents
        bus.wr_en    = 1'b1;
        bus.wr_bank  = 2'd2;
        bus.wr_index = 4'd5;
        bus.wr_rgb   = 12'hA5C;
        pix(2'd2, 4'd5);
        bus.wr_en = 1'b0;
        m_pal[2][5] = 12'hA5C;
        pix(2'd2, 4'd5);
        bus.wr_en    = 1'b1;
        bus.wr_bank  = 2'd3;
        bus.wr_index = 4'd9;
        bus.wr_rgb   = 12'h123;
        step();
        bus.wr_bank  = 2'd1;
        bus.wr_rgb   = 12'h7E1;
        step();
        bus.wr_en = 1'b0;
        m_pal[1][9] = 12'h7E1;
        pix(2'd1, 4'd9);
        pix(2'd2, 4'd9);
        repeat (3) step();

        flash_rgb = 12'hFFF;
        flash_start();
        step();
        check_eq("flash_act_on", flash_active, 1);
        pix(2'd1, 4'd0);
        pix(2'd2, 4'd0);
        pix(2'd0, 4'd3);
        pix(2'd3, 4'd3);
        repeat (3) step();

        // fresh flash: 2 frames on, 2 off, 2 on, 2 off, then idle
        flash_start();
        pix(2'd0, 4'd3);
        pix(2'd0, 4'd3);
        for (int f = 1; f <= 8; f++) begin
            frame_pulse();
            m_on = (f < 8) && (((f / 2) % 2) == 0);
            check_eq($sformatf("flash_act_f%0d", f), flash_active, (f < 8) ? 1 : 0);
            pix(2'd0, 4'd3);
            pix(2'd0, 4'd3);
        end
        frame_pulse();
        check_eq("idle_ignores_frame", flash_active, 0);
        repeat (3) step();

        // restart landing on the last frame reloads the full 8-frame run
        flash_start();
        for (int f = 1; f <= 7; f++) frame_pulse();
        flash_req   = 1'b1;
        frame_start = 1'b1;
        step();
        flash_req   = 1'b0;
        frame_start = 1'b0;
        m_on = 1'b1;
        step();
        check_eq("restart_active", flash_active, 1);
        pix(2'd0, 4'd3);
        for (int f = 1; f <= 8; f++) begin
            frame_pulse();
            m_on = (f < 8) && (((f / 2) % 2) == 0);
            check_eq($sformatf("restart_f%0d", f), flash_active, (f < 8) ? 1 : 0);
            pix(2'd0, 4'd2);
        end
        repeat (3) step();

        flash_start();
        pix(2'd3, 4'd4);
        pix(2'd3, 4'd0);
        repeat (3) step();
        pix(2'd0, 4'd2);
        pix(2'd0, 4'd6);
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", bus.out_valid, 0);
        check_eq("rst_mid_flash", flash_active, 0);
        check_eq("rst_mid_rgb", {bus.red, bus.green, bus.blue}, 0);
        sb.delete();
        model_reset();
        step();
        reset_n = 1'b1;
        step();
        step();
        check_eq("post_rst_valid", bus.out_valid, 0);
        pix(2'd2, 4'd5);
        pix(2'd0, 4'd14);
        repeat (4) step();
        check_eq("sb_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
